// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the iterative shifter.
// State encoding, shift clamp limit and default step size.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shf_state_t;

    localparam logic [5:0] SHIFT_MAX = 6'd32;
    localparam int         STEP_DEF  = 4;

    // Counts above the data width collapse to a full-width shift.
    function automatic logic [5:0] clamp_cnt(input logic [5:0] c);
        return (c > SHIFT_MAX) ? SHIFT_MAX : c;
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/status bundle between the datapath sequencer and iter_shifter.
// master: start/a/cnt/arith/ctr out, busy/done in; slave is the reverse.
interface iter_shifter_if;

    logic        start;
    logic [31:0] a;
    logic [5:0]  cnt;
    logic        arith;
    logic        ctr;
    logic        busy;
    logic        done;

    modport master (
        output start, a, cnt, arith, ctr,
        input  busy, done
    );

    modport slave (
        input  start, a, cnt, arith, ctr,
        output busy, done
    );

endinterface

// File: rtl/iter_shifter_shift_step.sv
// One combinational right-shift step of 0..STEP bits with fill.
// Ports: acc in, s amount (<= STEP), fill bit, y shifted result.
module shift_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       s,
    input  logic             fill,
    output logic [WIDTH-1:0] y
);

    // Small mux over constant shift amounts; never shifts by >= WIDTH.
    always_comb begin
        y = acc;
        for (int i = 1; i <= STEP; i++) begin
            if (s == 4'(i)) begin
                y = (acc >> i) | ({WIDTH{fill}} << (WIDTH - i));
            end
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle right shifter (SRL/SRA, CLZ de-normalisation), STEP bits/cycle.
// Ports: clk, rst (async high), bus (slave handshake), z (tri-state result).
module iter_shifter
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    iter_shifter_if.slave     bus,
    output wire [WIDTH-1:0]   z
);

    shf_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [5:0]       rem_q, rem_d;
    logic             fill_q, fill_d;

    logic [3:0]       s;
    logic [5:0]       n;
    logic [WIDTH-1:0] step_y;

    // Per-cycle amount: whatever remains, capped at STEP.
    assign s = (rem_q < 6'(STEP)) ? rem_q[3:0] : 4'(STEP);
    assign n = clamp_cnt(bus.cnt);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc  (acc_q),
        .s    (s),
        .fill (fill_q),
        .y    (step_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.a;
                    fill_d  = bus.arith & bus.a[WIDTH-1];
                    rem_d   = n;
                    state_d = (n == 6'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = step_y;
                rem_d = rem_q - {2'b00, s};
                if (rem_q <= 6'(STEP)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

    // Shared ALU result bus: drive only when enabled.
    assign z = bus.ctr ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter.
// Hand-computed vectors: latency, result, busy length, reset, tri-state.
module tb_iter_shifter;

    logic        clk;
    logic        rst;
    wire  [31:0] z;
    int          nvec;
    int          nbad;

    iter_shifter_if bus ();

    iter_shifter #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transaction; el = expected edges from start to done.
    task automatic run(input string       tag,
                       input logic [31:0] av,
                       input logic [5:0]  cv,
                       input logic        ar,
                       input logic [31:0] ez,
                       input int          el,
                       input bit          tog);
        int j;
        int nb;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.cnt   = cv;
        bus.arith = ar;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.cnt   = 6'd1;
        bus.arith = ~ar;
        j    = 0;
        nb   = 0;
        seen = 1'b0;
        while (!seen && j < 40) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (tog) begin
                if (j == 2) chk({tag, "_hiz"}, z, 32'hzzzz_zzzz);
                if (j == 1) bus.ctr = 1'b0;
                if (j == 2) bus.ctr = 1'b1;
            end
            if (bus.done) seen = 1'b1;
            else j++;
        end
        chk({tag, "_lat"}, 32'(j), 32'(el));
        chk({tag, "_z"}, z, ez);
        chk({tag, "_busy"}, 32'(nb), 32'(el + 1));
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        nvec      = 0;
        nbad      = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.cnt   = '0;
        bus.arith = 1'b0;
        bus.ctr   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_z", z, 32'd0);
        chk("rst_bd", {30'd0, bus.busy, bus.done}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a shift.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hF000_0000;
        bus.cnt   = 6'd20;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_z", z, 32'd0);
        chk("arst_bd", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("after_rst", 32'hF000_0000, 6'd20, 1'b0, 32'h0000_0F00, 5, 1'b0);
        run("srl13",     32'h8000_0001, 6'd13, 1'b0, 32'h0004_0000, 4, 1'b0);
        run("sra31",     32'h8000_0000, 6'd31, 1'b1, 32'hFFFF_FFFF, 8, 1'b0);
        run("clamp45",   32'hFFFF_FFFF, 6'd45, 1'b0, 32'h0000_0000, 8, 1'b0);
        run("sra32",     32'h8000_0000, 6'd32, 1'b1, 32'hFFFF_FFFF, 8, 1'b0);
        run("clamp63",   32'h7FFF_FFFF, 6'd63, 1'b1, 32'h0000_0000, 8, 1'b0);
        run("sra_pos",   32'h4000_0000, 6'd3,  1'b1, 32'h0800_0000, 1, 1'b0);
        run("sra5",      32'h8000_0000, 6'd5,  1'b1, 32'hFC00_0000, 2, 1'b0);
        run("srl_neg",   32'h8000_0000, 6'd5,  1'b0, 32'h0400_0000, 2, 1'b0);
        run("clz_rt",    32'hA000_0000, 6'd20, 1'b0, 32'h0000_0A00, 5, 1'b0);
        run("tristate",  32'hFFFF_0000, 6'd16, 1'b0, 32'h0000_FFFF, 4, 1'b1);

        // Zero count with start held through DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h1234_5678;
        bus.cnt   = 6'd0;
        bus.arith = 1'b0;
        @(negedge clk);
        chk("zero_done", {31'd0, bus.done}, 32'd1);
        chk("zero_z", z, 32'h1234_5678);
        bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("zero_hold", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("zero_zkeep", z, 32'h1234_5678);
        bus.start = 1'b0;
        @(negedge clk);
        chk("zero_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
